// File: rtl/enc_pkg.sv
// Shared constants and state encodings for the serial 4-to-2 priority encoder.
package enc_pkg;

    localparam int unsigned N_IN   = 4;
    localparam int unsigned CODE_W = 2;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_DRAIN = 1'b1;

    function automatic logic more_than_one(input logic [N_IN-1:0] v);
        return (v & (v - 1'b1)) != '0;
    endfunction

endpackage

// File: rtl/encoder4x2_serial_if.sv
// Request-in / code-out handshake bundle for encoder4x2_serial.
interface encoder4x2_serial_if;
    import enc_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [N_IN-1:0]   in_vec;
    logic              out_valid;
    logic              out_ready;
    logic [CODE_W-1:0] out_code;
    logic              out_last;
    logic              multi_hot;
    logic              err_zero;

    modport master (
        output in_valid, in_vec, out_ready,
        input  in_ready, out_valid, out_code, out_last, multi_hot, err_zero
    );

    modport slave (
        input  in_valid, in_vec, out_ready,
        output in_ready, out_valid, out_code, out_last, multi_hot, err_zero
    );

endinterface

// File: rtl/encoder4x2_serial_prio_enc.sv
// LSB-first 4-to-2 priority encoder built from a chain of 2:1 mux cells.
module mux2x1 #(
    parameter int unsigned W = 1
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         sel,
    output logic [W-1:0] y
);
    assign y = sel ? b : a;
endmodule

module prio_enc4x2
    import enc_pkg::*;
(
    input  logic [N_IN-1:0]   v,
    output logic [CODE_W-1:0] code,
    output logic              one_hot
);
    logic [CODE_W-1:0] m2;
    logic [CODE_W-1:0] m1;

    // Chain runs from the highest index inward so bit 0 has final say.
    mux2x1 #(.W(CODE_W)) u_m2 (.a(2'd3), .b(2'd2), .sel(v[2]), .y(m2));
    mux2x1 #(.W(CODE_W)) u_m1 (.a(m2),   .b(2'd1), .sel(v[1]), .y(m1));
    mux2x1 #(.W(CODE_W)) u_m0 (.a(m1),   .b(2'd0), .sel(v[0]), .y(code));

    assign one_hot = (v != '0) && !more_than_one(v);
endmodule

// File: rtl/encoder4x2_serial.sv
// Captures a 4-bit request vector and emits the index of each set bit, lowest first.
module encoder4x2_serial
    import enc_pkg::*;
(
    input logic                 clk,
    input logic                 rst,
    encoder4x2_serial_if.slave  bus
);
    logic [0:0]        state;
    logic [N_IN-1:0]   pend;
    logic              multi_hot;
    logic              err_zero;
    logic [CODE_W-1:0] code;
    logic              one_hot;
    logic              draining;

    prio_enc4x2 u_prio (.v(pend), .code(code), .one_hot(one_hot));

    assign draining      = (state == ST_DRAIN);
    assign bus.in_ready  = (state == ST_IDLE) && !rst;
    assign bus.out_valid = draining;
    assign bus.out_code  = draining ? code : '0;
    assign bus.out_last  = draining && one_hot;
    assign bus.multi_hot = multi_hot;
    assign bus.err_zero  = err_zero;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            pend      <= '0;
            multi_hot <= 1'b0;
            err_zero  <= 1'b0;
        end else begin
            multi_hot <= 1'b0;
            err_zero  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        if (bus.in_vec != '0) begin
                            pend      <= bus.in_vec;
                            state     <= ST_DRAIN;
                            multi_hot <= more_than_one(bus.in_vec);
                        end else begin
                            err_zero  <= 1'b1;
                        end
                    end
                end
                default: begin
                    if (bus.out_ready) begin
                        if (one_hot) begin
                            pend  <= '0;
                            state <= ST_IDLE;
                        end else begin
                            pend  <= pend & ~(4'b0001 << code);
                        end
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_encoder4x2_serial.sv
// Directed and randomized checks of encoder4x2_serial against a queue-based model.
module tb_encoder4x2_serial;
    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    // Reference: list of codes still to emit, plus expected pulse flags.
    int unsigned q[$];
    logic        exp_mh;
    logic        exp_ez;

    encoder4x2_serial_if bus ();

    encoder4x2_serial dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Apply inputs for one cycle, check outputs, then advance model and clock.
    task automatic cycle(input logic r, input logic iv, input logic [3:0] vec, input logic ordy);
        int unsigned n;
        rst           = r;
        bus.in_valid  = iv;
        bus.in_vec    = vec;
        bus.out_ready = ordy;
        #1;
        n = q.size();
        check("out_valid", {7'd0, bus.out_valid}, {7'd0, n != 0});
        check("out_code",  {6'd0, bus.out_code},  (n != 0) ? 8'(q[0]) : 8'd0);
        check("out_last",  {7'd0, bus.out_last},  {7'd0, n == 1});
        check("in_ready",  {7'd0, bus.in_ready},  {7'd0, (n == 0) && !r});
        check("multi_hot", {7'd0, bus.multi_hot}, {7'd0, exp_mh});
        check("err_zero",  {7'd0, bus.err_zero},  {7'd0, exp_ez});
        exp_mh = 1'b0;
        exp_ez = 1'b0;
        if (r) begin
            q.delete();
        end else if (n == 0 && iv) begin
            if (vec == 4'd0) begin
                exp_ez = 1'b1;
            end else begin
                for (int unsigned i = 0; i < 4; i++)
                    if (vec[i]) q.push_back(i);
                exp_mh = ($countones(vec) > 1);
            end
        end else if (n != 0 && ordy) begin
            void'(q.pop_front());
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_vec = '0;
        bus.out_ready = 1'b0;
        exp_mh = 1'b0;
        exp_ez = 1'b0;
        @(posedge clk);
        #1;
        cycle(1, 0, 4'd0, 0);
        cycle(1, 0, 4'd0, 0);
        cycle(0, 0, 4'd0, 0);

        // single bit
        cycle(0, 1, 4'b0100, 1);
        cycle(0, 0, 4'd0, 1);
        cycle(0, 0, 4'd0, 1);

        // multi-hot drain
        cycle(0, 1, 4'b1011, 1);
        repeat (4) cycle(0, 0, 4'd0, 1);

        // backpressure
        cycle(0, 1, 4'b0110, 0);
        repeat (3) cycle(0, 1, 4'b1111, 0);
        repeat (3) cycle(0, 0, 4'd0, 1);

        // zero vector
        cycle(0, 1, 4'd0, 1);
        cycle(0, 0, 4'd0, 1);
        cycle(0, 0, 4'd0, 1);

        // reset mid-drain
        cycle(0, 1, 4'b1111, 1);
        cycle(0, 0, 4'd0, 1);
        cycle(1, 1, 4'b0101, 1);
        cycle(0, 0, 4'd0, 1);
        cycle(0, 1, 4'b1000, 0);
        cycle(0, 0, 4'd0, 0);
        cycle(0, 0, 4'd0, 1);
        cycle(0, 0, 4'd0, 1);

        for (int k = 0; k < 400; k++) begin
            cycle(($urandom_range(0, 49) == 0),
                  ($urandom_range(0, 1) == 1),
                  4'($urandom_range(0, 15)),
                  ($urandom_range(0, 9) < 7));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
